uart_tx_feeder: RTL and testbench

Byte buffer and launch controller directly upstream of the UART transmitter. Accepts bytes from the USB3300 parser side at arbitrary burst rate, stores them in a synchronous FIFO, and drains them one at a time into the transmitter through its data, send and transmission-in-progress handshake. Decouples parser bursts from the serial line rate; drops bytes only when the FIFO is full, and flags every drop.

---
 rtl/uart_tx_feeder_pkg.sv | 16 +
 rtl/uart_tx_feeder_if.sv | 28 ++
 rtl/byte_fifo.sv | 66 ++++++
 rtl/uart_tx_feeder.sv | 83 ++++++++
 tb/tb_uart_tx_feeder.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder: byte width, drain FSM
// encoding and the ARM-state timeout.
package uart_tx_feeder_pkg;

  localparam int DATA_W      = 8;
  localparam int ARM_TIMEOUT = 4;
  localparam int ARM_CNT_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ARM   = 2'd2,
    ST_BUSY  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Parser-side write port, FIFO status and UART handshake of the feeder.
// The slave side is the feeder; the master side drives bytes and models the UART.
interface uart_tx_feeder_if #(
  parameter int DEPTH_LOG2 = 4
);
  import uart_tx_feeder_pkg::*;

  logic [DATA_W-1:0]   wr_data;
  logic                wr_en;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;
  logic [DATA_W-1:0]   tx_data;
  logic                tx_send;
  logic                tx_busy;

  modport master (
    output wr_data, wr_en, tx_busy,
    input  full, empty, level, overflow, tx_data, tx_send
  );

  modport slave (
    input  wr_data, wr_en, tx_busy,
    output full, empty, level, overflow, tx_data, tx_send
  );

endinterface

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with registered occupancy count; full/empty are
// registered alongside the count so every status output comes from a flop.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_en,
  output logic [DATA_W-1:0]   rd_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_nxt;
  logic                  do_wr;
  logic                  do_rd;

  // A write is refused on the registered full flag, even if a pop frees a slot this cycle.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  always_comb begin
    count_nxt = count;
    if (do_wr && !do_rd)
      count_nxt = count + 1'b1;
    else if (!do_wr && do_rd)
      count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers parser bytes and launches them one at a time into the UART through
// its data / send / transmission-in-progress handshake, retrying unanswered sends.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rstn,
  uart_tx_feeder_if.slave  bus
);

  state_t                state;
  logic [ARM_CNT_W-1:0]  arm_cnt;
  logic [DATA_W-1:0]     head;
  logic                  pop;

  // Pop is combinational so the head lands in tx_data on the same edge the FSM leaves IDLE.
  assign pop = (state == ST_IDLE) && !bus.empty && !bus.tx_busy;

  byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (bus.full),
    .empty   (bus.empty),
    .level   (bus.level)
  );

  always_ff @(posedge clk) begin
    if (!rstn)
      bus.overflow <= 1'b0;
    else if (bus.wr_en && bus.full)
      bus.overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      arm_cnt     <= '0;
      bus.tx_send <= 1'b0;
      bus.tx_data <= '0;
    end else begin
      bus.tx_send <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            bus.tx_data <= head;
            bus.tx_send <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          arm_cnt <= '0;
          state   <= ST_ARM;
        end
        ST_ARM: begin
          // An unanswered send is re-issued with the byte still held in tx_data.
          if (bus.tx_busy) begin
            state <= ST_BUSY;
          end else if (arm_cnt == ARM_CNT_W'(ARM_TIMEOUT - 1)) begin
            bus.tx_send <= 1'b1;
            state       <= ST_ISSUE;
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end
        ST_BUSY: begin
          if (!bus.tx_busy)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: a queue-based FIFO model predicts the
// accepted bytes and status flags; a UART model answers the send handshake.
module tb_uart_tx_feeder;
  import uart_tx_feeder_pkg::*;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  uart_tx_feeder_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  uart_tx_feeder #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_on = 1'b0;

  logic [7:0] exp_q[$];
  int  occ        = 0;
  bit  ovf_exp    = 1'b0;
  int  n_pulse    = 0;
  int  frame_len  = 10;
  int  ignore_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // UART: busy rises two cycles after a send pulse and lasts frame_len cycles; no reset.
  int arm_dly   = 0;
  int busy_left = 0;
  initial bus.tx_busy = 1'b0;
  always @(posedge clk) begin
    logic snd;
    snd = bus.tx_send;
    if (busy_left > 0) busy_left--;
    if (arm_dly > 0) begin
      arm_dly--;
      if (arm_dly == 0) busy_left = frame_len;
    end
    if (snd === 1'b1) begin
      if (ignore_cnt > 0) ignore_cnt--;
      else arm_dly = 1;
    end
    #1 bus.tx_busy = (busy_left > 0);
  end

  // Reference model: occupancy and expected byte order from accepted writes.
  bit m_first    = 1'b1;
  bit m_saw_busy = 1'b0;
  always @(negedge clk) begin
    if (mon_on) begin
      // A send not preceded by a retry means a byte left the FIFO the cycle before.
      if (bus.tx_send === 1'b1) begin
        if (m_first || m_saw_busy) occ--;
        m_first    = 1'b0;
        m_saw_busy = 1'b0;
      end
      if (bus.tx_busy === 1'b1) m_saw_busy = 1'b1;
      chk("level", 32'(bus.level), 32'(occ));
      chk("empty", 32'(bus.empty), 32'(occ == 0));
      chk("full", 32'(bus.full), 32'(occ == DEPTH));
      chk("overflow", 32'(bus.overflow), 32'(ovf_exp));
      if (!rstn) begin
        occ     = 0;
        ovf_exp = 1'b0;
        exp_q.delete();
        m_first = 1'b1;
      end else if (bus.wr_en) begin
        if (occ < DEPTH) begin
          exp_q.push_back(bus.wr_data);
          occ++;
        end else begin
          ovf_exp = 1'b1;
        end
      end
    end
  end

  // Monitor: every send pulse is compared against the scoreboard.
  bit         c_first     = 1'b1;
  bit         c_saw_busy  = 1'b0;
  logic       c_prev_send = 1'b0;
  logic [7:0] cur         = 8'h00;
  bit         cur_valid   = 1'b0;
  int         last_pulse  = 0;
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.tx_send === 1'b1) begin
        n_pulse++;
        chk("send_consecutive", 32'(c_prev_send), 32'd0);
        chk("send_while_busy", 32'(bus.tx_busy), 32'd0);
        if (c_first || c_saw_busy) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            cur_valid = 1'b0;
            $display("FAIL unexpected_send actual tx_data=%0h required=no send (cycle %0d)", bus.tx_data, cyc);
          end else begin
            cur       = exp_q.pop_front();
            cur_valid = 1'b1;
          end
        end else begin
          chk("retry_gap", 32'(cyc - last_pulse), 32'(ARM_TIMEOUT + 1));
        end
        if (cur_valid) chk("tx_data", 32'(bus.tx_data), 32'(cur));
        c_first    = 1'b0;
        c_saw_busy = 1'b0;
        last_pulse = cyc;
      end
      if (bus.tx_busy === 1'b1) c_saw_busy = 1'b1;
      c_prev_send = bus.tx_send;
      if (!rstn) c_first = 1'b1;
    end
  end

  task automatic drive(input logic en, input logic [7:0] d);
    bus.wr_en   = en;
    bus.wr_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int maxc);
    int k     = 0;
    int quiet = 0;
    bus.wr_en = 1'b0;
    while (k < maxc && (exp_q.size() != 0 || quiet < 8)) begin
      if (bus.tx_busy === 1'b0 && bus.tx_send !== 1'b1) quiet++;
      else quiet = 0;
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (k >= maxc) begin
      errors++;
      $display("FAIL drain_timeout actual pending=%0d required pending=0", exp_q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int p0;
    int k;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_data", 32'(bus.tx_data), 32'h00);
    chk("reset_tx_send", 32'(bus.tx_send), 32'd0);
    chk("reset_empty", 32'(bus.empty), 32'd1);
    rstn   = 1'b1;
    mon_on = 1'b1;

    // Single byte with a long UART frame.
    frame_len = 100;
    p0 = n_pulse;
    drive(1'b1, 8'hA5);
    drain(600);
    chk("single_pulses", 32'(n_pulse - p0), 32'd1);
    frame_len = 10;

    // Burst past capacity.
    for (int i = 0; i < 20; i++) drive(1'b1, 8'(i));
    chk("burst_overflow", 32'(bus.overflow), 32'd1);

    // Keep writing while full across pops.
    p0 = n_pulse;
    k  = 0;
    while (n_pulse < p0 + 2 && k < 200) begin
      drive(1'b1, 8'hE0 ^ 8'(k));
      k++;
    end
    chk("full_pop_wait_expired", 32'(k >= 200), 32'd0);
    drain(3000);

    // First send ignored by the UART, then retried.
    ignore_cnt = 1;
    p0 = n_pulse;
    drive(1'b1, 8'h3C);
    drain(300);
    chk("retry_pulses", 32'(n_pulse - p0), 32'd2);

    // Reset mid-frame with bytes queued.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h70 + 8'(i));
    k = 0;
    while (bus.tx_busy !== 1'b1 && k < 50) begin
      drive(1'b0, 8'h00);
      k++;
    end
    chk("busy_wait_expired", 32'(k >= 50), 32'd0);
    rstn = 1'b0;
    drive(1'b0, 8'h00);
    rstn = 1'b1;
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    p0 = n_pulse;
    drain(300);
    chk("post_reset_pulses", 32'(n_pulse - p0), 32'd0);

    // One byte every third cycle.
    for (int i = 0; i < 40; i++) drive(i % 3 == 0, 8'($urandom));
    drain(1000);

    // Random traffic, frame lengths and ignored sends.
    for (int i = 0; i < 300; i++) begin
      if (ignore_cnt == 0 && $urandom_range(0, 30) == 0) ignore_cnt = 1;
      frame_len = $urandom_range(3, 12);
      drive($urandom_range(0, 3) == 0, 8'($urandom));
    end
    drain(5000);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
